// File: rtl/uart_monitor.sv
// rtl/uart_monitor.sv - byte-stream command interpreter bridging UART FIFOs to an 8-bit memory bus
// Commands: 'R' addr len, 'W' addr len data..., 'E' byte; anything else answers '?'.
module uart_monitor #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata,
  output logic                  busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN, S_RD_REQ, S_RD_WAIT, S_RD_SEND,
    S_WR_DATA, S_WR_STB, S_SEND_ACK, S_SEND_ERR, S_ECHO, S_ECHO_TX
  } state_t;

  state_t                state_q, state_d;
  logic                  op_wr_q, op_wr_d;
  logic [7:0]            addr_h_q, addr_h_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            cnt_q, cnt_d;
  logic [7:0]            data_q, data_d;
  logic [15:0]           addr_full;
  logic                  rx_fire;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_wr_q  <= 1'b0;
      addr_h_q <= 8'd0;
      addr_q   <= '0;
      cnt_q    <= 9'd0;
      data_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      op_wr_q  <= op_wr_d;
      addr_h_q <= addr_h_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
    end
  end

  // Output decode depends only on state registers, never on rx/tx handshake inputs.
  always_comb begin
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN, S_WR_DATA, S_ECHO: rx_ready = 1'b1;
      S_RD_SEND, S_SEND_ACK, S_SEND_ERR, S_ECHO_TX:         tx_valid = 1'b1;
      S_RD_REQ:                                             mem_re   = 1'b1;
      S_WR_STB:                                             mem_we   = 1'b1;
      default: ;
    endcase
  end

  assign tx_data   = data_q;
  assign mem_wdata = data_q;
  assign mem_addr  = addr_q;
  assign busy      = (state_q != S_IDLE);
  assign rx_fire   = rx_valid & rx_ready;
  assign addr_full = {addr_h_q, rx_data};

  always_comb begin
    state_d  = state_q;
    op_wr_d  = op_wr_q;
    addr_h_d = addr_h_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: if (rx_fire) begin
        case (rx_data)
          8'h52: begin op_wr_d = 1'b0; state_d = S_ADDR_H; end
          8'h57: begin op_wr_d = 1'b1; state_d = S_ADDR_H; end
          8'h45: state_d = S_ECHO;
          default: begin data_d = 8'h3F; state_d = S_SEND_ERR; end
        endcase
      end
      S_ADDR_H: if (rx_fire) begin
        addr_h_d = rx_data;
        state_d  = S_ADDR_L;
      end
      S_ADDR_L: if (rx_fire) begin
        addr_d  = addr_full[ADDR_WIDTH-1:0];
        state_d = S_LEN;
      end
      // A length byte of zero means 256 transfers.
      S_LEN: if (rx_fire) begin
        cnt_d   = {(rx_data == 8'd0), rx_data};
        state_d = op_wr_q ? S_WR_DATA : S_RD_REQ;
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        data_d  = mem_rdata;
        state_d = S_RD_SEND;
      end
      S_RD_SEND: if (tx_ready) begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        cnt_d   = cnt_q - 9'd1;
        state_d = (cnt_q == 9'd1) ? S_IDLE : S_RD_REQ;
      end
      S_WR_DATA: if (rx_fire) begin
        data_d  = rx_data;
        state_d = S_WR_STB;
      end
      // The strobe cycle refuses rx, so write strobes can never be back to back.
      S_WR_STB: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        cnt_d  = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          data_d  = 8'h4B;
          state_d = S_SEND_ACK;
        end else begin
          state_d = S_WR_DATA;
        end
      end
      S_SEND_ACK, S_SEND_ERR, S_ECHO_TX: if (tx_ready) state_d = S_IDLE;
      S_ECHO: if (rx_fire) begin
        data_d  = rx_data;
        state_d = S_ECHO_TX;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_monitor.sv
// tb/tb_uart_monitor.sv - scoreboard bench for uart_monitor with a behavioural memory
module tb_uart_monitor;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'd0;
  logic        busy;

  logic [7:0]  mem [0:65535];
  logic [7:0]  exp_q[$];
  logic [15:0] re_addr_q[$];

  int checks = 0;
  int failures = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  int overlap_err = 0;
  int consec_err = 0;
  int stab_err = 0;
  logic       we_prev = 1'b0;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'd0;

  uart_monitor #(.ADDR_WIDTH(16)) dut (
    .CLK(CLK), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory: read data appears the cycle after the strobe.
  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  always @(negedge CLK) begin
    if (!reset) begin
      we_prev   = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (mem_re && mem_we) overlap_err++;
      if (mem_we && we_prev) consec_err++;
      we_prev = mem_we;
      if (mem_re) begin re_cnt++; re_addr_q.push_back(mem_addr); end
      if (mem_we) we_cnt++;
      if (hold_prev && (!tx_valid || tx_data != hold_data)) stab_err++;
      hold_prev = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check_eq("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
        else check_eq("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    repeat (gap) step();
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      if (rx_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("rx_accept_timeout", 32'd0, 32'd1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLK);
      if (!busy && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq(tag, 32'd0, 32'd1);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rx_ready"},  {31'd0, rx_ready}, 32'd1);
    check_eq({tag, "_tx_valid"},  {31'd0, tx_valid}, 32'd0);
    check_eq({tag, "_tx_data"},   {24'd0, tx_data}, 32'd0);
    check_eq({tag, "_mem_addr"},  {16'd0, mem_addr}, 32'd0);
    check_eq({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    check_eq({tag, "_mem_we"},    {31'd0, mem_we}, 32'd0);
    check_eq({tag, "_mem_re"},    {31'd0, mem_re}, 32'd0);
    check_eq({tag, "_busy"},      {31'd0, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] <= 8'd0;
    #1;
    check_reset_outputs("reset0");
    repeat (3) step();
    reset = 1'b1;
    step();

    // Echo
    re_cnt = 0; we_cnt = 0;
    exp_q.push_back(8'h41);
    send_byte(8'h45, 0);
    send_byte(8'h41, 0);
    wait_done("echo_timeout");
    check_eq("echo_busy", {31'd0, busy}, 32'd0);
    check_eq("echo_re_cnt", re_cnt, 0);
    check_eq("echo_we_cnt", we_cnt, 0);

    // Read three bytes
    mem[16'h1234] <= 8'hAA; mem[16'h1235] <= 8'hBB; mem[16'h1236] <= 8'hCC;
    step();
    re_cnt = 0; re_addr_q.delete();
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
    send_byte(8'h52, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h03, 0);
    wait_done("read_timeout");
    check_eq("read_re_cnt", re_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      if (re_addr_q.size() > 0) check_eq("read_re_addr", {16'd0, re_addr_q.pop_front()}, 32'h1234 + i);
    end

    // Write 256 bytes starting at 0xFFFF, wrapping to 0x0000
    we_cnt = 0;
    exp_q.push_back(8'h4B);
    send_byte(8'h57, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0); send_byte(8'h00, 0);
    for (int k = 0; k < 256; k++) send_byte(8'(k), (k % 7 == 3) ? 2 : 0);
    wait_done("write_timeout");
    check_eq("write_we_cnt", we_cnt, 256);
    check_eq("write_mem_ffff", {24'd0, mem[16'hFFFF]}, 32'h00);
    for (int k = 1; k < 256; k++) check_eq("write_mem", {24'd0, mem[16'(k - 1)]}, k);
    check_eq("write_mem_00ff_untouched", {24'd0, mem[16'h00FF]}, 32'h00);

    // Backpressure: each byte held 10 cycles before tx_ready
    mem[16'h0010] <= 8'h5C; mem[16'h0011] <= 8'hA7;
    step();
    re_cnt = 0; stab_err = 0;
    tx_ready = 1'b0;
    exp_q.push_back(8'h5C); exp_q.push_back(8'hA7);
    send_byte(8'h52, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h02, 0);
    for (int b = 0; b < 2; b++) begin
      bit seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge CLK);
        if (tx_valid) begin seen = 1'b1; break; end
      end
      if (!seen) check_eq("bp_tx_valid_timeout", 32'd0, 32'd1);
      repeat (10) @(negedge CLK);
      step();
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
    end
    tx_ready = 1'b1;
    wait_done("bp_timeout");
    check_eq("bp_re_cnt", re_cnt, 2);
    check_eq("bp_stable", stab_err, 0);
    check_eq("bp_exp_left", exp_q.size(), 0);

    // Unknown command then echoes with rx gaps
    exp_q.push_back(8'h3F);
    send_byte(8'h5A, 3);
    exp_q.push_back(8'h09);
    send_byte(8'h45, 2);
    send_byte(8'h09, 4);
    exp_q.push_back(8'h3F);
    send_byte(8'h00, 1);
    wait_done("unknown_timeout");

    // Reset in the middle of a 4-byte write after 2 data bytes
    send_byte(8'h57, 0); send_byte(8'h20, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    step(); step();
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    repeat (3) step();
    reset = 1'b1;
    step();
    check_eq("reset_mem_2000", {24'd0, mem[16'h2000]}, 32'h11);
    check_eq("reset_mem_2001", {24'd0, mem[16'h2001]}, 32'h22);
    check_eq("reset_mem_2002", {24'd0, mem[16'h2002]}, 32'h00);
    exp_q.push_back(8'h07);
    send_byte(8'h45, 0);
    send_byte(8'h07, 0);
    wait_done("post_reset_timeout");
    repeat (20) step();

    check_eq("exp_queue_empty", exp_q.size(), 0);
    check_eq("re_we_overlap", overlap_err, 0);
    check_eq("we_consecutive", consec_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
